// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the handshaked pipeline stage registers:
//               skid FSM state encoding, per-stage payload structs and the
//               canonical NOP instruction used as a reset/flush payload.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Occupancy of a stage: nothing, main register only, main plus skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // IF/ID payload: fetch PC followed by the fetched instruction word
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // addi x0, x0, 0 - inserted by stages that reset or flush to a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Valid/ready pipeline stage bundle. The slave modport is the
//               stage register itself; the master modport is the surrounding
//               logic that feeds it upstream and drains it downstream.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = $bits(if_id_t)
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Handshaked pipeline stage register with synchronous flush.
//               Default build is a single register whose in_ready is
//               combinational on out_ready. Defining PIPE_STAGE_SKID_EN adds
//               a skid register so in_ready comes only from stage state.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = $bits(if_id_t),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    pipe_stage_reg_if.slave   bus
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_up_xfer;
    logic              w_dn_xfer;

    assign w_up_xfer     = bus.in_valid && bus.in_ready;
    assign w_dn_xfer     = r_valid && bus.out_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;

    // Only a full skid blocks upstream, so in_ready never sees out_ready
    assign bus.in_ready = (r_state != FULL);
    assign r_valid      = (r_state != EMPTY);

    // State register plus main/skid payload registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= EMPTY;
            r_data      <= RESET_VAL;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.flush) begin
                r_data <= RESET_VAL;
            end else if (w_load_main) begin
                r_data <= bus.in_data;
            end else if (w_main_from_skid) begin
                r_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= bus.in_data;
            end
        end
    end

    // Next state and payload steering; flush empties the stage from any state
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_up_xfer) begin
                        w_state_nxt = ONE;
                        w_load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_up_xfer) begin
                        // Downstream stalled: park the new beat behind main
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_dn_xfer) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_dn_xfer) begin
                        w_state_nxt      = ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

`else

    // The register can take a beat whenever its current one is leaving
    assign bus.in_ready = !r_valid || bus.out_ready;

    // Single payload register; data holds when the beat drains without refill
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (w_up_xfer) begin
            r_valid <= 1'b1;
            r_data  <= bus.in_data;
        end else if (w_dn_xfer) begin
            r_valid <= 1'b0;
        end
    end

`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed and scoreboarded bench for pipe_stage_reg. Honours
//               PIPE_STAGE_SKID_EN so the same bench covers both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int          DW    = 64;
    localparam logic [63:0] RST_V = {32'h0000_0000, NOP_INSTR};
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   cnt7;

    pipe_stage_reg_if #(.DATA_W(DW)) bus ();

    pipe_stage_reg #(
        .DATA_W    (DW),
        .RESET_VAL (RST_V)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream monitor: count handshakes carrying 0x7
    always @(posedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready && bus.out_data == 64'h7) begin
            cnt7 <= cnt7 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] q[$];
    logic [63:0] exp_d;
    bit          up, dn, fl;

    initial begin
        checks        = 0;
        errors        = 0;
        cnt7          = 0;
        rstn          = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_data", bus.out_data, RST_V);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Streaming 1..4 at full rate
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(i);
            #1;
            check("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
            tick();
            check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
            check("stream_data", bus.out_data, 64'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        check("drain_valid", {63'd0, bus.out_valid}, 64'd0);
        check("drain_hold", bus.out_data, 64'd4);

        // Stall: 0xA held while 0xB is offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hA;
        tick();
        bus.in_data = 64'hB;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", {63'd0, bus.in_ready}, {63'd0, (SKID && k == 0)});
            tick();
            check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
            check("stall_data", bus.out_data, 64'hA);
        end
        // Skid already owns 0xB; single register still has it pending upstream
        if (SKID) bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("release_valid", {63'd0, bus.out_valid}, 64'd1);
        check("release_data", bus.out_data, 64'hB);
        tick();
        check("release_empty", {63'd0, bus.out_valid}, 64'd0);

        // Flush with the stage as full as it gets, 0x55 offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hC;
        tick();
        bus.in_data = 64'hD;
        tick();
        check("pre_flush_data", bus.out_data, 64'hC);
        bus.flush   = 1'b1;
        bus.in_data = 64'h55;
        #1;
        check("pre_flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        check("flush_data", bus.out_data, RST_V);
        check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        tick();
        check("flush_no_55", {63'd0, bus.out_valid}, 64'd0);

        // Transfer right after flush, then flush alongside a downstream beat
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h9;
        tick();
        check("post_flush_data", bus.out_data, 64'h9);
        bus.in_data = 64'h7;
        tick();
        check("seven_data", bus.out_data, 64'h7);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_dn_valid", {63'd0, bus.out_valid}, 64'd0);
        check("flush_dn_data", bus.out_data, RST_V);
        tick();
        check("seven_count", 64'(cnt7), 64'd1);

        // Asynchronous reset between edges
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h3C;
        tick();
        bus.in_valid = 1'b0;
        check("pre_arst_valid", {63'd0, bus.out_valid}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_data", bus.out_data, RST_V);
        tick();
        rstn = 1'b1;
        #1;
        check("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Random traffic against an in-order queue model
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            bus.in_data   = {$urandom, $urandom};
            #1;
            check("rnd_in_ready", {63'd0, bus.in_ready},
                  {63'd0, (SKID ? (q.size() < 2) : (q.size() == 0 || bus.out_ready))});
            up = bus.in_valid && bus.in_ready;
            dn = bus.out_valid && bus.out_ready;
            fl = bus.flush;
            if (dn) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 64'd1, 64'd0);
                end else begin
                    exp_d = q.pop_front();
                    check("rnd_data", bus.out_data, exp_d);
                end
            end
            if (fl) q.delete();
            else if (up) q.push_back(bus.in_data);
            tick();
            check("rnd_valid", {63'd0, bus.out_valid}, {63'd0, (q.size() != 0)});
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
